udp_rx_frame_window: RTL and testbench

- Upstream stage of the seven-segment display path, in the udp_rx_clk domain.
- Accepts the raw UDP payload byte stream from the UDP RX core and hunts for a 0xAA header.
- Assembles header plus 8 payload bytes into one 72-bit frame word, then emits a one-cycle app_rx_data_valid pulse with app_rx_data_buffer for the display controller downstream.
- Drops malformed or stalled frames and keeps good/bad frame counters for debug.

---
 rtl/udp_rx_frame_window.sv | 148 ++++++++++++++
 tb/tb_udp_rx_frame_window.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_frame_window.sv
// Frames the UDP RX payload stream into 72-bit {0xAA, 8 payload bytes} words for the display path.
// Optional trailing XOR checksum byte enabled by `define UDP_RX_FRAME_CHECKSUM_EN.
module udp_rx_frame_window #(
   parameter logic [7:0] HEADER         = 8'hAA,
   parameter int         PAYLOAD_BYTES  = 8,
   parameter int         TIMEOUT_CYCLES = 125000
) (
   input  logic        udp_rx_clk,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        rx_byte_valid,
   input  logic        rx_pkt_end,
   output logic        app_rx_data_valid,
   output logic [71:0] app_rx_data_buffer,
   output logic [15:0] frame_ok_cnt,
   output logic [15:0] frame_err_cnt,
   output logic        rx_busy
);

   localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [2:0]     LAST_IDX = 3'(PAYLOAD_BYTES - 1);

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1
`ifdef UDP_RX_FRAME_CHECKSUM_EN
      ,ST_CHECK  = 2'd2
`endif
   } state_t;

   state_t          state;
   logic [63:0]     pay;
   logic [2:0]      idx;
   logic [TW-1:0]   tmo_cnt;
   logic            tmo_hit;
`ifdef UDP_RX_FRAME_CHECKSUM_EN
   logic [7:0]      csum;
`endif

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // A zero timeout parameter removes the idle abort entirely.
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

   always_ff @(posedge udp_rx_clk or negedge reset) begin
      if (!reset) begin
         state              <= ST_HUNT;
         pay                <= '0;
         idx                <= '0;
         tmo_cnt            <= '0;
`ifdef UDP_RX_FRAME_CHECKSUM_EN
         csum               <= '0;
`endif
         app_rx_data_valid  <= 1'b0;
         app_rx_data_buffer <= '0;
         frame_ok_cnt       <= '0;
         frame_err_cnt      <= '0;
         rx_busy            <= 1'b0;
      end else begin
         app_rx_data_valid <= 1'b0;
         unique case (state)
            ST_HUNT: begin
               tmo_cnt <= '0;
               // A header that is also the packet's last byte cannot start a frame.
               if (rx_byte_valid && rx_byte == HEADER && !rx_pkt_end) begin
                  state   <= ST_PAYLOAD;
                  rx_busy <= 1'b1;
                  idx     <= '0;
                  pay     <= '0;
`ifdef UDP_RX_FRAME_CHECKSUM_EN
                  csum    <= '0;
`endif
               end
            end

            ST_PAYLOAD: begin
               if (rx_byte_valid) begin
                  tmo_cnt <= '0;
                  pay     <= {pay[55:0], rx_byte};
                  idx     <= idx + 3'd1;
`ifdef UDP_RX_FRAME_CHECKSUM_EN
                  csum    <= csum ^ rx_byte;
`endif
                  if (idx == LAST_IDX) begin
`ifdef UDP_RX_FRAME_CHECKSUM_EN
                     if (rx_pkt_end) begin
                        state         <= ST_HUNT;
                        rx_busy       <= 1'b0;
                        frame_err_cnt <= sat_inc(frame_err_cnt);
                     end else begin
                        state <= ST_CHECK;
                     end
`else
                     state              <= ST_HUNT;
                     rx_busy            <= 1'b0;
                     app_rx_data_valid  <= 1'b1;
                     app_rx_data_buffer <= {HEADER, pay[55:0], rx_byte};
                     frame_ok_cnt       <= sat_inc(frame_ok_cnt);
`endif
                  end else if (rx_pkt_end) begin
                     state         <= ST_HUNT;
                     rx_busy       <= 1'b0;
                     frame_err_cnt <= sat_inc(frame_err_cnt);
                  end
               end else if (tmo_hit) begin
                  state         <= ST_HUNT;
                  rx_busy       <= 1'b0;
                  frame_err_cnt <= sat_inc(frame_err_cnt);
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end

`ifdef UDP_RX_FRAME_CHECKSUM_EN
            ST_CHECK: begin
               if (rx_byte_valid) begin
                  tmo_cnt <= '0;
                  state   <= ST_HUNT;
                  rx_busy <= 1'b0;
                  if (rx_byte == csum) begin
                     app_rx_data_valid  <= 1'b1;
                     app_rx_data_buffer <= {HEADER, pay};
                     frame_ok_cnt       <= sat_inc(frame_ok_cnt);
                  end else begin
                     frame_err_cnt <= sat_inc(frame_err_cnt);
                  end
               end else if (tmo_hit) begin
                  state         <= ST_HUNT;
                  rx_busy       <= 1'b0;
                  frame_err_cnt <= sat_inc(frame_err_cnt);
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
`endif

            default: begin
               state   <= ST_HUNT;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_rx_frame_window.sv
// Directed scenarios plus a randomized run against a queue-based frame model.
module tb_udp_rx_frame_window;
   localparam int TMO = 16;

   logic        udp_rx_clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_byte_valid = 1'b0;
   logic        rx_pkt_end = 1'b0;
   logic        app_rx_data_valid;
   logic [71:0] app_rx_data_buffer;
   logic [15:0] frame_ok_cnt;
   logic [15:0] frame_err_cnt;
   logic        rx_busy;

   int n_tests = 0;
   int n_fail  = 0;

   udp_rx_frame_window #(.HEADER(8'hAA), .PAYLOAD_BYTES(8), .TIMEOUT_CYCLES(TMO)) dut (
      .udp_rx_clk(udp_rx_clk), .reset(reset),
      .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_pkt_end(rx_pkt_end),
      .app_rx_data_valid(app_rx_data_valid), .app_rx_data_buffer(app_rx_data_buffer),
      .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt), .rx_busy(rx_busy)
   );

   always #5 udp_rx_clk = ~udp_rx_clk;

   // Reference: a frame is "open" after a header; bytes collect in a queue.
   bit          m_in;
   logic [7:0]  m_q[$];
   int          m_idle;
   logic        m_valid;
   logic [71:0] m_buf;
   logic [15:0] m_ok, m_err;

   task automatic model_reset();
      m_in = 0; m_q.delete(); m_idle = 0; m_valid = 0; m_buf = '0; m_ok = '0; m_err = '0;
   endtask

   task automatic model_abort();
      if (m_err != 16'hFFFF) m_err++;
      m_in = 0;
   endtask

   task automatic model_commit();
      m_buf = 72'hAA;
      foreach (m_q[k]) m_buf = {m_buf[63:0], m_q[k]};
      m_valid = 1;
      if (m_ok != 16'hFFFF) m_ok++;
      m_in = 0;
   endtask

   function automatic logic [7:0] q_xor();
      logic [7:0] x = 8'h00;
      foreach (m_q[k]) x ^= m_q[k];
      return x;
   endfunction

   task automatic model_step(input bit v, input logic [7:0] b, input bit e);
      m_valid = 0;
      if (!m_in) begin
         if (v && b == 8'hAA && !e) begin
            m_in = 1; m_q.delete(); m_idle = 0;
         end
      end else if (v) begin
         m_idle = 0;
         if (m_q.size() < 8) begin
            m_q.push_back(b);
            if (m_q.size() == 8) begin
`ifdef UDP_RX_FRAME_CHECKSUM_EN
               if (e) model_abort();
`else
               model_commit();
`endif
            end else if (e) begin
               model_abort();
            end
         end else begin
            if (b == q_xor()) model_commit();
            else model_abort();
         end
      end else begin
         m_idle++;
         if (TMO != 0 && m_idle == TMO) model_abort();
      end
   endtask

   task automatic cyc(input bit v, input logic [7:0] b, input bit e);
      rx_byte_valid = v; rx_byte = b; rx_pkt_end = e;
      @(posedge udp_rx_clk);
      model_step(v, b, e);
      @(negedge udp_rx_clk);
      rx_byte_valid = 1'b0; rx_pkt_end = 1'b0;
   endtask

   // Header + 8 payload bytes (+ checksum when enabled); pkt_end on the last byte sent.
   task automatic send_frame(input logic [63:0] p, input bit end_last);
      logic [7:0] x = 8'h00;
      cyc(1, 8'hAA, 0);
      for (int k = 0; k < 8; k++) begin
         x ^= p[63-8*k -: 8];
`ifdef UDP_RX_FRAME_CHECKSUM_EN
         cyc(1, p[63-8*k -: 8], 0);
`else
         cyc(1, p[63-8*k -: 8], (k == 7) && end_last);
`endif
      end
`ifdef UDP_RX_FRAME_CHECKSUM_EN
      cyc(1, x, end_last);
`endif
   endtask

   task automatic do_reset();
      reset = 1'b0; rx_byte_valid = 1'b0; rx_pkt_end = 1'b0; rx_byte = 8'h00;
      model_reset();
      repeat (2) @(negedge udp_rx_clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({app_rx_data_valid, app_rx_data_buffer, frame_ok_cnt, frame_err_cnt, rx_busy} !== 106'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b buf=%h ok=%h err=%h busy=%b, want all zero",
                  app_rx_data_valid, app_rx_data_buffer, frame_ok_cnt, frame_err_cnt, rx_busy);
      end
      repeat (2) @(negedge udp_rx_clk);
      reset = 1'b1;
      cyc(0, 8'h00, 0);
      n_tests++;
      if (rx_busy !== 1'b0 || app_rx_data_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b v=%b, want 0 0", rx_busy, app_rx_data_valid);
      end
   endtask

   task automatic test_basic();
      do_reset();
      cyc(1, 8'hAA, 0);
      n_tests++;
      if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", rx_busy); end
      for (int k = 0; k < 7; k++) cyc(1, 8'h12 + 8'(k) * 8'h22, 0);
      n_tests++;
      if (app_rx_data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", app_rx_data_valid); end
`ifdef UDP_RX_FRAME_CHECKSUM_EN
      cyc(1, 8'hF0, 0);
      cyc(1, 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0, 0);
`else
      cyc(1, 8'hF0, 0);
`endif
      n_tests++;
      if (app_rx_data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", app_rx_data_valid); end
      n_tests++;
      if (app_rx_data_buffer !== 72'hAA123456789ABCDEF0) begin
         n_fail++; $display("FAIL basic_buf: got %h want AA123456789ABCDEF0", app_rx_data_buffer);
      end
      n_tests++;
      if (frame_ok_cnt !== 16'd1 || frame_err_cnt !== 16'd0) begin
         n_fail++; $display("FAIL basic_cnt: got ok=%0d err=%0d want 1 0", frame_ok_cnt, frame_err_cnt);
      end
      cyc(0, 8'h00, 0);
      n_tests++;
      if (app_rx_data_valid !== 1'b0 || rx_busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_pulse_width: got v=%b busy=%b want 0 0", app_rx_data_valid, rx_busy);
      end
   endtask

   task automatic test_hunt();
      do_reset();
      cyc(1, 8'h00, 0);
      cyc(1, 8'h55, 0);
      cyc(1, 8'hAA, 1);
      n_tests++;
      if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL hunt_hdr_pkt_end: got busy=%b want 0", rx_busy); end
      send_frame(64'h0102030405060708, 0);
      n_tests++;
      if (app_rx_data_valid !== 1'b1 || app_rx_data_buffer !== 72'hAA0102030405060708) begin
         n_fail++; $display("FAIL hunt_buf: got v=%b buf=%h want 1 AA0102030405060708", app_rx_data_valid, app_rx_data_buffer);
      end
      n_tests++;
      if (frame_err_cnt !== 16'd0) begin n_fail++; $display("FAIL hunt_err: got %0d want 0", frame_err_cnt); end
   endtask

   task automatic test_abort();
      do_reset();
      send_frame(64'hCAFEBABE01234567, 1);
      cyc(1, 8'hAA, 0);
      cyc(1, 8'h01, 0);
      cyc(1, 8'h02, 0);
      cyc(1, 8'h03, 1);
      n_tests++;
      if (app_rx_data_valid !== 1'b0 || app_rx_data_buffer !== 72'hAACAFEBABE01234567) begin
         n_fail++; $display("FAIL abort_buf: got v=%b buf=%h want 0 AACAFEBABE01234567", app_rx_data_valid, app_rx_data_buffer);
      end
      n_tests++;
      if (frame_err_cnt !== 16'd1 || frame_ok_cnt !== 16'd1 || rx_busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_cnt: got err=%0d ok=%0d busy=%b want 1 1 0", frame_err_cnt, frame_ok_cnt, rx_busy);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      cyc(1, 8'hAA, 0);
      cyc(1, 8'h01, 0);
      cyc(1, 8'h02, 0);
      repeat (TMO - 1) cyc(0, 8'h00, 0);
      n_tests++;
      if (rx_busy !== 1'b1 || frame_err_cnt !== 16'd0) begin
         n_fail++; $display("FAIL timeout_early: got busy=%b err=%0d want 1 0", rx_busy, frame_err_cnt);
      end
      cyc(0, 8'h00, 0);
      n_tests++;
      if (rx_busy !== 1'b0 || frame_err_cnt !== 16'd1) begin
         n_fail++; $display("FAIL timeout_hit: got busy=%b err=%0d want 0 1", rx_busy, frame_err_cnt);
      end
      send_frame(64'h1122334455667788, 0);
      n_tests++;
      if (app_rx_data_buffer !== 72'hAA1122334455667788 || frame_ok_cnt !== 16'd1) begin
         n_fail++; $display("FAIL timeout_next: got buf=%h ok=%0d want AA1122334455667788 1", app_rx_data_buffer, frame_ok_cnt);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_frame(64'hAAAAAAAAAAAAAAAA, 0);
      n_tests++;
      if (app_rx_data_valid !== 1'b1 || app_rx_data_buffer !== 72'hAAAAAAAAAAAAAAAAAA) begin
         n_fail++; $display("FAIL b2b_first: got v=%b buf=%h want 1 AAAAAAAAAAAAAAAAAA", app_rx_data_valid, app_rx_data_buffer);
      end
      send_frame(64'h0F1E2D3C4B5A6978, 0);
      n_tests++;
      if (app_rx_data_valid !== 1'b1 || app_rx_data_buffer !== 72'hAA0F1E2D3C4B5A6978 || frame_ok_cnt !== 16'd2) begin
         n_fail++; $display("FAIL b2b_second: got v=%b buf=%h ok=%0d want 1 AA0F1E2D3C4B5A6978 2",
                            app_rx_data_valid, app_rx_data_buffer, frame_ok_cnt);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      send_frame(64'h0102030405060708, 0);
      cyc(1, 8'hAA, 0);
      cyc(1, 8'h01, 0);
      cyc(1, 8'h02, 0);
      #2 reset = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({app_rx_data_valid, app_rx_data_buffer, frame_ok_cnt, frame_err_cnt, rx_busy} !== 106'h0) begin
         n_fail++; $display("FAIL midreset_outputs: got buf=%h ok=%0d err=%0d busy=%b want all zero",
                            app_rx_data_buffer, frame_ok_cnt, frame_err_cnt, rx_busy);
      end
      @(negedge udp_rx_clk);
      reset = 1'b1;
      send_frame(64'h1122334455667788, 0);
      n_tests++;
      if (app_rx_data_buffer !== 72'hAA1122334455667788 || frame_ok_cnt !== 16'd1 || frame_err_cnt !== 16'd0) begin
         n_fail++; $display("FAIL midreset_next: got buf=%h ok=%0d err=%0d want AA1122334455667788 1 0",
                            app_rx_data_buffer, frame_ok_cnt, frame_err_cnt);
      end
   endtask

`ifdef UDP_RX_FRAME_CHECKSUM_EN
   task automatic test_checksum();
      do_reset();
      cyc(1, 8'hAA, 0);
      for (int k = 1; k <= 8; k++) cyc(1, 8'(k), 0);
      cyc(1, 8'h09, 0);
      n_tests++;
      if (app_rx_data_valid !== 1'b0 || frame_err_cnt !== 16'd1 || frame_ok_cnt !== 16'd0) begin
         n_fail++; $display("FAIL csum_bad: got v=%b err=%0d ok=%0d want 0 1 0", app_rx_data_valid, frame_err_cnt, frame_ok_cnt);
      end
      cyc(1, 8'hAA, 0);
      for (int k = 1; k <= 8; k++) cyc(1, 8'(k), k == 8);
      n_tests++;
      if (frame_err_cnt !== 16'd2 || rx_busy !== 1'b0) begin
         n_fail++; $display("FAIL csum_missing: got err=%0d busy=%b want 2 0", frame_err_cnt, rx_busy);
      end
   endtask
`endif

   task automatic test_random();
      int idle_left = 0;
      int shown = 0;
      bit v, e;
      logic [7:0] b;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (idle_left == 0 && $urandom_range(0, 99) < 2) idle_left = $urandom_range(12, 18);
         if (idle_left > 0) begin
            v = 0; idle_left--;
         end else begin
            v = ($urandom_range(0, 99) < 80);
         end
         if (m_in && m_q.size() == 8 && $urandom_range(0, 99) < 70) b = q_xor();
         else if ($urandom_range(0, 99) < 25) b = 8'hAA;
         else b = 8'($urandom);
         e = ($urandom_range(0, 99) < 8);
         cyc(v, b, e);
         n_tests++;
         if (app_rx_data_valid !== m_valid || app_rx_data_buffer !== m_buf || frame_ok_cnt !== m_ok ||
             frame_err_cnt !== m_err || rx_busy !== m_in) begin
            n_fail++;
            if (shown < 10) begin
               shown++;
               $display("FAIL random_cycle%0d: got v=%b buf=%h ok=%0d err=%0d busy=%b want v=%b buf=%h ok=%0d err=%0d busy=%b",
                        i, app_rx_data_valid, app_rx_data_buffer, frame_ok_cnt, frame_err_cnt, rx_busy,
                        m_valid, m_buf, m_ok, m_err, m_in);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hunt();
      test_abort();
      test_timeout();
      test_back_to_back();
      test_mid_reset();
`ifdef UDP_RX_FRAME_CHECKSUM_EN
      test_checksum();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
